// File: rtl/cadd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cadd_pkg                                                                   |
// | Shared types and helpers for the complex-add arbiter slice.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cadd_pkg;
  localparam int DW  = 16;
  localparam int IDW = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] g, input int n);
    return (int'(g) >= n - 1) ? '0 : g + 1'b1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/adder_16bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_16bit                                                                |
// | Pipelined binary16 adder, round-to-nearest-even, LAT register stages.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module adder_16bit #(
  parameter int LAT = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  // Subnormals flush to zero; exponent overflow saturates to infinity.
  function automatic logic [15:0] fp16_add(input logic [15:0] p, input logic [15:0] q);
    logic [15:0] x, y;
    logic [10:0] mx, my;
    logic [14:0] s, ys;
    logic [11:0] m;
    int          ex, ey, d;
    if (p[14:0] >= q[14:0]) begin x = p; y = q; end
    else                    begin x = q; y = p; end
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    mx = (ex == 0) ? 11'd0 : {1'b1, x[9:0]};
    my = (ey == 0) ? 11'd0 : {1'b1, y[9:0]};
    if (mx == 11'd0) return 16'h0000;
    d  = (my == 11'd0) ? 14 : ex - ey;
    ys = {1'b0, my, 3'b000};
    if (d > 13)
      ys = {14'd0, |my};
    else if (d > 0)
      ys = (ys >> d) | {14'd0, |(ys & ((15'd1 << d) - 15'd1))};
    s = (x[15] ^ y[15]) ? ({1'b0, mx, 3'b000} - ys) : ({1'b0, mx, 3'b000} + ys);
    if (s == 15'd0) return 16'h0000;
    if (s[14]) begin
      s  = {1'b0, s[14:2], s[1] | s[0]};
      ex = ex + 1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!s[13] && ex > 1) begin
        s  = s << 1;
        ex = ex - 1;
      end
    end
    if (!s[13]) return {x[15], 15'd0};
    m = {1'b0, s[13:3]};
    if (s[2] && (s[1] || s[0] || s[3])) m = m + 12'd1;
    if (m[11]) begin
      m  = m >> 1;
      ex = ex + 1;
    end
    if (ex >= 31) return {x[15], 5'h1f, 10'h000};
    return {x[15], 5'(ex), m[9:0]};
  endfunction

  logic [15:0] r_pipe [LAT];

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= fp16_add(a, b);
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign sum = r_pipe[LAT-1];
endmodule
`default_nettype wire

// File: rtl/cadd_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cadd_rr_picker                                                             |
// | Combinational round-robin pick: first set request at or after ptr.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cadd_rr_picker
  import cadd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);
  int w_idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    w_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (j == w_idx && req[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
          gidx     = IDW'(j);
          any      = 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/complex_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | complex_adder                                                              |
// | Two adder_16bit lanes (real, imaginary) with a common latency.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module complex_adder #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] a_real,
  input  logic [15:0] a_imag,
  input  logic [15:0] b_real,
  input  logic [15:0] b_imag,
  output logic [15:0] sum_real,
  output logic [15:0] sum_imag
);
  adder_16bit #(.LAT(LAT)) u_re (.CLK(CLK), .rst(rst), .a(a_real), .b(b_real), .sum(sum_real));
  adder_16bit #(.LAT(LAT)) u_im (.CLK(CLK), .rst(rst), .a(a_imag), .b(b_imag), .sum(sum_imag));
endmodule
`default_nettype wire

// File: rtl/complex_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | complex_add_arbiter                                                        |
// | Round-robin sharing of one complex_adder with tag-routed responses and a   |
// | drain FSM. Optional per-requester issue counters: CADD_ARB_STATS_EN.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module complex_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int ADD_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 rst,
`ifdef CADD_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [NREQ*16-1:0]   issue_cnt,
`endif
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a_real,
  input  logic [NREQ*DW-1:0]   req_a_imag,
  input  logic [NREQ*DW-1:0]   req_b_real,
  input  logic [NREQ*DW-1:0]   req_b_imag,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_real,
  output logic [DW-1:0]        rsp_imag,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic                 busy
);
  import cadd_pkg::*;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  tag_t            r_tag [ADD_LAT];
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gidx;
  logic            w_any, w_grant_en, w_issue, w_busy, w_rsp_v;
  logic [DW-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  logic [DW-1:0]   w_sum_re, w_sum_im, r_hold_re, r_hold_im;

  cadd_rr_picker #(.NREQ(NREQ)) u_picker (
    .req(req_valid), .ptr(r_rr_ptr), .grant(w_grant), .gidx(w_gidx), .any(w_any)
  );

  // Drain wins over a same-cycle request: RUN only grants when drain_req is low.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    drain_done  = 1'b0;
    case (r_state)
      RUN:     if (drain_req) w_state_nxt = DRAIN; else w_grant_en = 1'b1;
      DRAIN:   if (!w_busy) begin drain_done = !rst; w_state_nxt = IDLE; end
      IDLE:    if (!drain_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_issue   = w_any & w_grant_en & ~rst;
  assign req_ready = w_issue ? w_grant : '0;

  always_comb begin
    w_a_re = '0;
    w_a_im = '0;
    w_b_re = '0;
    w_b_im = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_issue && w_gidx == IDW'(j)) begin
        w_a_re = req_a_real[j*DW +: DW];
        w_a_im = req_a_imag[j*DW +: DW];
        w_b_re = req_b_real[j*DW +: DW];
        w_b_im = req_b_imag[j*DW +: DW];
      end
    end
  end

  complex_adder #(.LAT(ADD_LAT)) u_cadd (
    .CLK(CLK), .rst(rst),
    .a_real(w_a_re), .a_imag(w_a_im), .b_real(w_b_re), .b_imag(w_b_im),
    .sum_real(w_sum_re), .sum_imag(w_sum_im)
  );

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < ADD_LAT; i++) w_busy = w_busy | r_tag[i].v;
  end
  assign busy = w_busy;

  // The tag pipe mirrors the adder latency, so its tail names the sum owner.
  assign w_rsp_v = r_tag[ADD_LAT-1].v & ~rst;
  always_comb begin
    rsp_valid = '0;
    for (int j = 0; j < NREQ; j++)
      rsp_valid[j] = w_rsp_v && (r_tag[ADD_LAT-1].id == IDW'(j));
  end
  assign rsp_real = w_rsp_v ? w_sum_re : r_hold_re;
  assign rsp_imag = w_rsp_v ? w_sum_im : r_hold_im;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= RUN;
      r_rr_ptr  <= '0;
      r_hold_re <= '0;
      r_hold_im <= '0;
      for (int i = 0; i < ADD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_issue) r_rr_ptr <= ptr_inc(w_gidx, NREQ);
      r_tag[0].v  <= w_issue;
      r_tag[0].id <= w_gidx;
      for (int i = 1; i < ADD_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (w_rsp_v) begin
        r_hold_re <= w_sum_re;
        r_hold_im <= w_sum_im;
      end
    end
  end

`ifdef CADD_ARB_STATS_EN
  logic [15:0] r_cnt [NREQ];

  always_ff @(posedge CLK) begin
    if (rst || stats_clr) begin
      for (int j = 0; j < NREQ; j++) r_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < NREQ; j++)
        if (req_ready[j]) r_cnt[j] <= r_cnt[j] + 16'd1;
    end
  end

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
      assign issue_cnt[g*16 +: 16] = r_cnt[g];
    end
  endgenerate
`endif
endmodule
`default_nettype wire

// File: tb/tb_complex_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_complex_add_arbiter                                                     |
// | Scoreboard bench: expected sums queued at grant, checked at response.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_complex_add_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 16;
  localparam int ADD_LAT = 2;

  logic                 CLK = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid;
  logic [NREQ*DW-1:0]   req_a_real, req_a_imag, req_b_real, req_b_imag;
  logic [DW-1:0]        rsp_real, rsp_imag;
  logic                 drain_req, drain_done, busy;
`ifdef CADD_ARB_STATS_EN
  logic                 stats_clr;
  logic [NREQ*16-1:0]   issue_cnt;
`endif

  complex_add_arbiter #(.NREQ(NREQ), .DW(DW), .ADD_LAT(ADD_LAT)) dut (
    .CLK(CLK), .rst(rst),
`ifdef CADD_ARB_STATS_EN
    .stats_clr(stats_clr), .issue_cnt(issue_cnt),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_real(req_a_real), .req_a_imag(req_a_imag),
    .req_b_real(req_b_real), .req_b_imag(req_b_imag),
    .rsp_valid(rsp_valid), .rsp_real(rsp_real), .rsp_imag(rsp_imag),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [15:0] re;
    logic [15:0] im;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ar[NREQ], ai[NREQ], br[NREQ], bi[NREQ];

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Integer -> binary16; exact for |v| < 2048.
  function automatic logic [15:0] enc(input int v);
    int          mag, p;
    logic [15:0] r;
    if (v == 0) return 16'h0000;
    mag = (v < 0) ? -v : v;
    p   = 0;
    for (int i = 0; i < 11; i++) if (mag >= (1 << i)) p = i;
    r[15]    = (v < 0);
    r[14:10] = 5'(p + 15);
    r[9:0]   = 10'((mag << (10 - p)) & 'h3ff);
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      ar[i] = int'($urandom_range(80)) - 40;
      ai[i] = int'($urandom_range(80)) - 40;
      br[i] = int'($urandom_range(80)) - 40;
      bi[i] = int'($urandom_range(80)) - 40;
      req_a_real[i*DW +: DW] = enc(ar[i]);
      req_a_imag[i*DW +: DW] = enc(ai[i]);
      req_b_real[i*DW +: DW] = enc(br[i]);
      req_b_imag[i*DW +: DW] = enc(bi[i]);
    end
  endtask

  task automatic push_exp(input int g);
    exp_t e;
    e.id  = g;
    e.re  = enc(ar[g] + br[g]);
    e.im  = enc(ai[g] + bi[g]);
    e.cyc = cyc;
    sbq.push_back(e);
  endtask

  // Response monitor: every rsp_valid must match the oldest queued expectation.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (rsp_valid !== '0) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: rsp_valid=%b real=%h, required no response", rsp_valid, rsp_real);
      end else begin
        e = sbq.pop_front();
        if (rsp_valid !== (NREQ'(1) << e.id) || rsp_real !== e.re || rsp_imag !== e.im ||
            cyc - e.cyc != ADD_LAT) begin
          failures++;
          $display("FAIL rsp: valid=%b real=%h imag=%h lat=%0d, required valid=%b real=%h imag=%h lat=%0d",
                   rsp_valid, rsp_real, rsp_imag, cyc - e.cyc,
                   NREQ'(1) << e.id, e.re, e.im, ADD_LAT);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; drain_req = 1'b0; req_valid = '1;
    set_ops();
    step(); step();
    @(negedge CLK);
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid: got %b, required 0000", rsp_valid); end
    checks++; if (rsp_real !== 16'h0 || rsp_imag !== 16'h0) begin failures++; $display("FAIL reset_rsp_data: got %h/%h, required 0000/0000", rsp_real, rsp_imag); end
    checks++; if (drain_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags: drain_done=%b busy=%b, required 0 0", drain_done, busy); end
    step();
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] want;
    for (int k = 0; k < 8; k++) begin
      set_ops();
      req_valid = '1;
      want = NREQ'(1) << (k % NREQ);
      @(negedge CLK);
      checks++;
      if (req_ready !== want) begin failures++; $display("FAIL fairness_grant%0d: got %b, required %b", k, req_ready, want); end
      push_exp(k % NREQ);
      step();
    end
    req_valid = '0;
    repeat (ADD_LAT + 1) step();
  endtask

  task automatic test_single();
    exp_t e;
    req_valid = 4'b0001;
    req_a_real[0 +: DW] = 16'h3C00; req_a_imag[0 +: DW] = 16'h4000;
    req_b_real[0 +: DW] = 16'h3C00; req_b_imag[0 +: DW] = 16'h0000;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b, required 0001", req_ready); end
    e.id = 0; e.re = 16'h4000; e.im = 16'h4000; e.cyc = cyc;
    sbq.push_back(e);
    step();
    req_valid = '0;
    repeat (ADD_LAT) step();
    @(negedge CLK);
    checks++;
    if (rsp_valid !== '0 || rsp_real !== 16'h4000 || rsp_imag !== 16'h4000) begin
      failures++;
      $display("FAIL single_hold: valid=%b data=%h/%h, required 0000 4000/4000", rsp_valid, rsp_real, rsp_imag);
    end
    step();
  endtask

  task automatic test_sparse();
    int seq[3] = '{3, 1, 3};
    set_ops();
    req_valid = 4'b0010;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL sparse_setup: got %b, required 0010", req_ready); end
    push_exp(1);
    step();
    for (int k = 0; k < 3; k++) begin
      set_ops();
      req_valid = 4'b1010;
      @(negedge CLK);
      checks++;
      if (req_ready !== (NREQ'(1) << seq[k])) begin
        failures++;
        $display("FAIL sparse_grant%0d: got %b, required %b", k, req_ready, NREQ'(1) << seq[k]);
      end
      push_exp(seq[k]);
      step();
    end
    req_valid = '0;
    repeat (ADD_LAT + 1) step();
  endtask

  task automatic test_drain();
    int   last_issue, done_cyc;
    bit   seen, leaked, resumed;
    set_ops();
    req_valid = '1;
    @(negedge CLK);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL drain_issue0: got %b, required 0001", req_ready); end
    push_exp(0);
    step();
    set_ops();
    @(negedge CLK);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL drain_issue1: got %b, required 0010", req_ready); end
    push_exp(1);
    last_issue = cyc;
    step();
    drain_req = 1'b1;
    @(negedge CLK);
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL drain_wins: got %b, required 0000", req_ready); end
    step();
    seen = 1'b0; leaked = 1'b0; done_cyc = -1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      if (req_ready !== '0) leaked = 1'b1;
      if (drain_done === 1'b1) begin seen = 1'b1; done_cyc = cyc; end
      else step();
    end
    checks++; if (leaked) begin failures++; $display("FAIL drain_no_grant: grant seen while draining, required none"); end
    checks++;
    if (!seen || done_cyc != last_issue + ADD_LAT + 1) begin
      failures++;
      $display("FAIL drain_done_cycle: got %0d, required %0d", done_cyc, last_issue + ADD_LAT + 1);
    end
    step();
    drain_req = 1'b0;
    resumed = 1'b0;
    for (int n = 0; n < 5 && !resumed; n++) begin
      @(negedge CLK);
      if (req_ready !== '0) resumed = 1'b1;
      else step();
    end
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL drain_resume: got %b, required 0100", req_ready); end
    if (resumed) push_exp(2);
    step();
    req_valid = '0;
    repeat (ADD_LAT + 1) step();
  endtask

  task automatic test_reset_midflight();
    set_ops();
    req_valid = 4'b0010;
    @(negedge CLK);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL midrst_issue0: got %b, required 0010", req_ready); end
    step();
    req_valid = 4'b0100;
    @(negedge CLK);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL midrst_issue1: got %b, required 0100", req_ready); end
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    repeat (ADD_LAT + 2) step();
    set_ops();
    req_valid = '1;
    @(negedge CLK);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr: got %b, required 0001", req_ready); end
    push_exp(0);
    step();
    req_valid = '0;
    repeat (ADD_LAT + 1) step();
  endtask

`ifdef CADD_ARB_STATS_EN
  task automatic test_stats();
    logic [NREQ*16-1:0] want;
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    @(negedge CLK);
    checks++; if (issue_cnt !== '0) begin failures++; $display("FAIL stats_clear0: got %h, required 0", issue_cnt); end
    step();
    for (int k = 0; k < 5; k++) begin
      set_ops();
      req_valid = 4'b0100;
      @(negedge CLK);
      if (req_ready === 4'b0100) push_exp(2);
      step();
    end
    req_valid = '0;
    want = '0;
    want[2*16 +: 16] = 16'd5;
    @(negedge CLK);
    checks++; if (issue_cnt !== want) begin failures++; $display("FAIL stats_count5: got %h, required %h", issue_cnt, want); end
    step();
    set_ops();
    req_valid = 4'b0100;
    stats_clr = 1'b1;
    @(negedge CLK);
    if (req_ready === 4'b0100) push_exp(2);
    step();
    stats_clr = 1'b0;
    req_valid = '0;
    @(negedge CLK);
    checks++; if (issue_cnt !== '0) begin failures++; $display("FAIL stats_clr_wins: got %h, required 0", issue_cnt); end
    repeat (ADD_LAT + 1) step();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef CADD_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_fairness();
    test_single();
    test_sparse();
    test_drain();
    test_reset_midflight();
`ifdef CADD_ARB_STATS_EN
    test_stats();
`endif
    repeat (ADD_LAT + 3) step();
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL rsp_missing: %0d responses outstanding, required 0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
